tdm_demux4: RTL
===============

Name: tdm_demux4

Overview:
- Four-channel time-division demultiplexer; the receive-side counterpart of the 4:1 channel mux.
- Takes one serial bit stream carrying a repeating frame of four WIDTH-bit slots, with slot k belonging to channel k.
- Deserializes each slot, MSB first, and presents it as a registered parallel word on the matching channel output with a one-cycle valid pulse.
- Sits between the serial link front end and the per-channel consumers.

Parameters:
- WIDTH, 8, bits per slot and width of each channel output word (legal range 2..16).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  1  serial data bit; sampled only when din_valid=1.
- din_valid  input  1  qualifies din and frame_sync for this cycle.
- frame_sync  input  1  marks the beat carrying slot 0 bit WIDTH-1 (first bit of a frame); meaningful only with din_valid=1.
- out0  output  WIDTH  last completed channel-0 word.
- out1  output  WIDTH  last completed channel-1 word.
- out2  output  WIDTH  last completed channel-2 word.
- out3  output  WIDTH  last completed channel-3 word.
- ch_valid  output  4  bit k pulses high for one cycle when outk is updated.
- frame_done  output  1  one-cycle pulse when slot 3 completes.
- locked  output  1  high while in LOCKED state.
- sync_err  output  1  one-cycle pulse on any framing violation.

Behaviour:
- Reset (rst_n=0, async): state=HUNT; out0..out3=0; ch_valid=0; frame_done=0; sync_err=0; locked=0; bit counter, slot counter and shift register cleared.
- Beat = cycle with din_valid=1. Cycles with din_valid=0 change no state; pulse outputs return to 0.
- All outputs are registered.
- HUNT state:
  - Beats with frame_sync=0 are discarded; no outputs change.
  - A beat with frame_sync=1 is taken as slot 0 bit 0 (MSB). On that edge: state goes to LOCKED, bit_cnt=1, slot=0, and din is shifted in.
- LOCKED state, per beat:
  - din shifts into the shift register, MSB first.
  - If bit_cnt<WIDTH-1, bit_cnt increments.
  - If bit_cnt==WIDTH-1, the word is complete. On that same edge:
    - out[slot] <= {shreg[WIDTH-2:0], din};
    - ch_valid[slot]=1 for the next cycle only;
    - bit_cnt=0;
    - slot increments, wrapping 3->0.
  - When slot 3 completes, frame_done=1 in the same cycle as ch_valid[3].
  - Latency: the output word and its valid are visible the cycle after the edge that samples the final bit.
- Framing rules in LOCKED:
  - Expected frame start is slot=0, bit_cnt=0. A beat there with frame_sync=1 is normal; continue.
  - A beat at expected frame start with frame_sync=0 (missing sync): sync_err pulse, beat discarded, state goes to HUNT, locked=0 next cycle.
  - A beat with frame_sync=1 at any other position (early sync): sync_err pulse; the partial word is discarded with no ch_valid; this beat becomes slot 0 bit 0 (bit_cnt=1, slot=0); stay LOCKED.
- Unaffected outputs hold their last value indefinitely. A channel output updates only when its own slot completes.
- Simultaneous events:
  - Final bit of slot 3 and frame_done complete on the same edge; the next beat is then the expected frame start.
  - sync_err and ch_valid never assert in the same cycle.
- Reset mid-frame: all state and outputs return to reset values immediately. The receiver must see a new frame_sync before it locks again.

Test Plan:
- WIDTH=8. Reset, then one frame of contiguous beats with sync on the first beat, slots 0xA5, 0x3C, 0xFF, 0x01 -> out0..3=A5/3C/FF/01; ch_valid pulses 0001, 0010, 0100, 1000 at beats 8/16/24/32 (+1 cycle); frame_done coincides with ch_valid[3]; sync_err never asserts.
- Same frame with din_valid deasserted on alternate cycles -> identical output words; every pulse is delayed accordingly; nothing changes during idle cycles.
- Two frames back-to-back with sync on beat 33 -> second frame's words replace the first; locked stays 1; no sync_err.
- Frame start beat with frame_sync=0 -> sync_err pulse; locked=0; outputs keep prior values; the next sync beat relocks.
- frame_sync=1 at slot 1 bit 3 -> sync_err pulse; no ch_valid[1]; the following 32 beats decode as a full frame from that beat.
- rst_n pulled low at slot 2 bit 4 -> all outputs 0 asynchronously; after release, beats without sync change nothing.

Source files
------------

// File: rtl/tdm_demux4.sv
// Four-channel TDM receiver: deserializes a framed serial stream of four
// WIDTH-bit slots (MSB first) into per-channel registered words with valid pulses.
module tdm_demux4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       ch_valid,
  output logic             frame_done,
  output logic             locked,
  output logic             sync_err
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned NCH = 4;

  typedef enum logic {
    S_HUNT   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [1:0]       r_slot, w_slot_nxt;
  logic [WIDTH-2:0] r_shreg, w_shreg_nxt;
  logic [WIDTH-1:0] r_out [NCH];
  logic [WIDTH-1:0] w_out_nxt [NCH];
  logic [3:0]       r_ch_valid, w_ch_valid_nxt;
  logic             r_frame_done, w_frame_done_nxt;
  logic             r_sync_err, w_sync_err_nxt;
  logic             r_locked;

  logic [WIDTH-1:0] w_word;
  logic             w_last_bit;
  logic             w_frame_start;

  assign w_word        = {r_shreg, din};
  assign w_last_bit    = (r_bit_cnt == CW'(WIDTH - 1));
  assign w_frame_start = (r_slot == 2'd0) && (r_bit_cnt == CW'(0));

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_HUNT;
      r_bit_cnt    <= '0;
      r_slot       <= '0;
      r_shreg      <= '0;
      r_ch_valid   <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      r_locked     <= 1'b0;
      for (int i = 0; i < int'(NCH); i++) r_out[i] <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_slot       <= w_slot_nxt;
      r_shreg      <= w_shreg_nxt;
      r_ch_valid   <= w_ch_valid_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_sync_err   <= w_sync_err_nxt;
      r_locked     <= (w_state_nxt == S_LOCKED);
      for (int i = 0; i < int'(NCH); i++) r_out[i] <= w_out_nxt[i];
    end
  end

  // Next-state: hunting for sync, then counting bits/slots and policing framing
  always_comb begin
    w_state_nxt      = r_state;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_slot_nxt       = r_slot;
    w_shreg_nxt      = r_shreg;
    w_ch_valid_nxt   = '0;
    w_frame_done_nxt = 1'b0;
    w_sync_err_nxt   = 1'b0;
    for (int i = 0; i < int'(NCH); i++) w_out_nxt[i] = r_out[i];

    if (din_valid) begin
      unique case (r_state)
        S_HUNT: begin
          if (frame_sync) begin
            w_state_nxt   = S_LOCKED;
            w_bit_cnt_nxt = CW'(1);
            w_slot_nxt    = 2'd0;
            w_shreg_nxt   = w_word[WIDTH-2:0];
          end
        end
        S_LOCKED: begin
          if (w_frame_start && !frame_sync) begin
            w_sync_err_nxt = 1'b1;
            w_state_nxt    = S_HUNT;
            w_bit_cnt_nxt  = '0;
            w_slot_nxt     = 2'd0;
          end else if (frame_sync && !w_frame_start) begin
            // Early sync wins over a completing word: restart the frame here
            w_sync_err_nxt = 1'b1;
            w_bit_cnt_nxt  = CW'(1);
            w_slot_nxt     = 2'd0;
            w_shreg_nxt    = w_word[WIDTH-2:0];
          end else begin
            w_shreg_nxt = w_word[WIDTH-2:0];
            if (w_last_bit) begin
              w_out_nxt[r_slot]      = w_word;
              w_ch_valid_nxt[r_slot] = 1'b1;
              w_frame_done_nxt       = (r_slot == 2'd3);
              w_bit_cnt_nxt          = '0;
              w_slot_nxt             = r_slot + 2'd1;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + CW'(1);
            end
          end
        end
        default: w_state_nxt = S_HUNT;
      endcase
    end
  end

  assign out0       = r_out[0];
  assign out1       = r_out[1];
  assign out2       = r_out[2];
  assign out3       = r_out[3];
  assign ch_valid   = r_ch_valid;
  assign frame_done = r_frame_done;
  assign sync_err   = r_sync_err;
  assign locked     = r_locked;

endmodule
